// File: rtl/spi_apb_master_pkg.sv
// Shared definitions for the SPI-facing APB requester: FSM codes, SPI register map
// and the default access timeout.
package spi_apb_master_pkg;

    // Codes match the existing completer FSM so traces line up across blocks.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam logic [2:0] REG_CR1 = 3'd0;
    localparam logic [2:0] REG_CR2 = 3'd1;
    localparam logic [2:0] REG_BR  = 3'd2;
    localparam logic [2:0] REG_SR  = 3'd3;
    localparam logic [2:0] REG_DR  = 3'd5;

    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/spi_apb_master.sv
// APB requester that turns one command into one SETUP/ACCESS transfer and returns
// a held response; a stuck completer is cut off after TIMEOUT ACCESS cycles.
module spi_apb_master
    import spi_apb_master_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              P_clk,
    input  logic              P_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              P_sel,
    output logic              P_enable,
    output logic              P_write,
    output logic [ADDR_W-1:0] P_addr,
    output logic [DATA_W-1:0] P_wdata,
    input  logic              P_ready,
    input  logic [DATA_W-1:0] P_rdata,
    input  logic              P_slverr
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    apb_state_t        state_q;
    apb_state_t        state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wait_cnt_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_to_q;

    logic cmd_hs;
    logic xfer_done;
    logic timeout_hit;

    assign cmd_ready   = P_rst && (state_q == IDLE) && !rsp_valid_q;
    assign cmd_hs      = cmd_valid && cmd_ready;
    assign xfer_done   = (state_q == ACCESS) && P_ready;
    // P_ready in the last allowed cycle still completes normally.
    assign timeout_hit = (state_q == ACCESS) && !P_ready && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_hs) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (xfer_done || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cmd_hs) begin
            wr_q    <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

    // Cleared in SETUP so it reads 0 on the first ACCESS cycle.
    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q == SETUP) begin
            wait_cnt_q <= 8'd0;
        end else if ((state_q == ACCESS) && !P_ready && !timeout_hit) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else if (xfer_done) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= wr_q ? '0 : P_rdata;
            rsp_err_q   <= P_slverr;
            rsp_to_q    <= 1'b0;
        end else if (timeout_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_to_q    <= 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;

    // Bus outputs decode straight from state so reset silences them without a clock.
    assign P_sel    = (state_q != IDLE);
    assign P_enable = (state_q == ACCESS);
    assign P_write  = P_sel && wr_q;
    assign P_addr   = P_sel ? addr_q  : '0;
    assign P_wdata  = P_sel ? wdata_q : '0;

endmodule
